// File: rtl/uart_rx_parity_engine.sv
// uart_rx_parity_engine
// Frame-aware UART receive parity checker. It sits between the RX bit
// sampler and the UART status register, latches the parity mode when a frame
// starts, counts the sampled data bits itself, and checks the parity bit
// against the parity of the received data.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous, active-high reset
//   Mode[2:0]    in   0=none 1=even 2=odd 3=mark 4=space, 5..7 act as none
//   Start        in   start-bit pulse, begins (or restarts) a frame
//   BitValid     in   strobe: RxD holds a mid-bit sample
//   RxD          in   sampled serial bit
//   ErrClear     in   clears the sticky RxParityErr flag
//   CntClear     in   clears ErrCount
//   Busy         out  high while a frame is being received (DATA or PARITY)
//   FrameDone    out  one-cycle pulse after the last expected bit of a frame
//   ParityErrP   out  one-cycle pulse alongside FrameDone on parity mismatch
//   RxParityErr  out  sticky parity error flag
//   ErrCount     out  saturating parity error counter
module uart_rx_parity_engine #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       Mode,
  input  logic             Start,
  input  logic             BitValid,
  input  logic             RxD,
  input  logic             ErrClear,
  input  logic             CntClear,
  output logic             Busy,
  output logic             FrameDone,
  output logic             ParityErrP,
  output logic             RxParityErr,
  output logic [CNT_W-1:0] ErrCount
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_EVEN  = 3'd1;
  localparam logic [2:0] MODE_ODD   = 3'd2;
  localparam logic [2:0] MODE_MARK  = 3'd3;
  localparam logic [2:0] MODE_SPACE = 3'd4;

  // Counter is wide enough to hold DATA_BITS so it never wraps inside a frame.
  localparam int             CW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Reserved encodings 5..7 collapse to "none" so later logic sees only 0..4.
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    logic [2:0] r;
    case (m)
      MODE_NONE, MODE_EVEN, MODE_ODD, MODE_MARK, MODE_SPACE: r = m;
      default:                                              r = MODE_NONE;
    endcase
    return r;
  endfunction

  // Parity bit the transmitter should have sent, given the XOR of the data.
  function automatic logic expected_parity(input logic [2:0] m, input logic acc);
    logic r;
    case (m)
      MODE_EVEN:  r = acc;
      MODE_ODD:   r = ~acc;
      MODE_MARK:  r = 1'b1;
      MODE_SPACE: r = 1'b0;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_r, state_s;
  logic             acc_r, acc_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [2:0]       mode_r, mode_s;
  logic             busy_r;
  logic             done_r, done_s;
  logic             perr_r, perr_s;
  logic             sticky_r, sticky_s;
  logic [CNT_W-1:0] err_cnt_r, err_cnt_s;

  // Next-state, frame accounting and error bookkeeping.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    cnt_s     = cnt_r;
    mode_s    = mode_r;
    done_s    = 1'b0;
    perr_s    = 1'b0;

    // Start always (re)opens a frame, even mid-frame; a coincident BitValid is dropped.
    if (Start) begin
      state_s = ST_DATA;
      acc_s   = 1'b0;
      cnt_s   = '0;
      mode_s  = norm_mode(Mode);
    end else if (BitValid) begin
      case (state_r)
        ST_DATA: begin
          acc_s = acc_r ^ RxD;
          cnt_s = cnt_r + CW'(1);
          if (cnt_r == LAST_BIT) begin
            if (mode_r == MODE_NONE) begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = ST_PARITY;
            end
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
          perr_s  = (RxD != expected_parity(mode_r, acc_r));
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    // A new error beats a coincident clear.
    if (perr_s) begin
      sticky_s = 1'b1;
    end else if (ErrClear) begin
      sticky_s = 1'b0;
    end else begin
      sticky_s = sticky_r;
    end

    if (CntClear) begin
      err_cnt_s = perr_s ? CNT_W'(1) : '0;
    end else if (perr_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_s = err_cnt_r + CNT_W'(1);
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      acc_r     <= 1'b0;
      cnt_r     <= '0;
      mode_r    <= MODE_NONE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      perr_r    <= 1'b0;
      sticky_r  <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      cnt_r     <= cnt_s;
      mode_r    <= mode_s;
      busy_r    <= (state_s != ST_IDLE);
      done_r    <= done_s;
      perr_r    <= perr_s;
      sticky_r  <= sticky_s;
      err_cnt_r <= err_cnt_s;
    end
  end

  assign Busy        = busy_r;
  assign FrameDone   = done_r;
  assign ParityErrP  = perr_r;
  assign RxParityErr = sticky_r;
  assign ErrCount    = err_cnt_r;

endmodule
